// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler owning HI/LO, with a fixed-latency busy window and a D-stage stall.
// Define MD_ABORT_EN to add the md_abort input, which cancels an in-flight op.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start_E,
    input  logic [2:0]  md_op_E,
    input  logic [31:0] rs_val_E,
    input  logic [31:0] rt_val_E,
    input  logic        md_use_D,
`ifdef MD_ABORT_EN
    input  logic        md_abort,
`endif
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] phi, plo, phi_n, plo_n, hi_n, lo_n;
    logic        abort, is_arith, is_div, is_signed, neg_a, neg_b, div_zero;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

`ifdef MD_ABORT_EN
    assign abort = md_abort;
`else
    assign abort = 1'b0;
`endif

    assign is_arith  = ~md_op_E[2];
    assign is_div    = md_op_E[1];
    assign is_signed = ~md_op_E[0];
    assign neg_a     = is_signed & rs_val_E[31];
    assign neg_b     = is_signed & rt_val_E[31];
    // Sign-extending to 64 bits lets one multiplier serve both MULT and MULTU
    assign prod      = {{32{neg_a}}, rs_val_E} * {{32{neg_b}}, rt_val_E};
    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping
    assign a_mag     = neg_a ? -rs_val_E : rs_val_E;
    assign b_mag     = neg_b ? -rt_val_E : rt_val_E;
    assign div_zero  = rt_val_E == 32'd0;
    assign q_mag     = div_zero ? 32'd0 : a_mag / b_mag;
    assign r_mag     = div_zero ? 32'd0 : a_mag % b_mag;
    assign quot      = (neg_a ^ neg_b) ? -q_mag : q_mag;
    assign rem       = neg_a ? -r_mag : r_mag;

    assign busy      = state == BUSY;
    assign stall_md  = md_use_D & (busy | (md_start_E & is_arith));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        phi_n   = phi;
        plo_n   = plo;
        hi_n    = hi;
        lo_n    = lo;
        if (state == IDLE) begin
            if (md_start_E && !abort && is_arith) begin
                state_n = BUSY;
                cnt_n   = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                phi_n   = !is_div ? prod[63:32] : div_zero ? hi : rem;
                plo_n   = !is_div ? prod[31:0]  : div_zero ? lo : quot;
            end else if (md_start_E && !abort) begin
                hi_n = md_op_E == 3'd4 ? rs_val_E : hi;
                lo_n = md_op_E == 3'd5 ? rs_val_E : lo;
            end
        end else if (abort) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            phi_n   = 32'd0;
            plo_n   = 32'd0;
        end else begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) begin
                state_n = IDLE;
                hi_n    = phi;
                lo_n    = plo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            phi   <= 32'd0;
            plo   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            phi   <= phi_n;
            plo   <= plo_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed self-checking bench for md_sched (covers md_abort when MD_ABORT_EN is defined).
module tb_md_sched;
    logic        clk = 0, reset = 1, md_start_E = 0, md_use_D = 0;
    logic [2:0]  md_op_E = 3'd6;
    logic [31:0] rs_val_E = 0, rt_val_E = 0;
    logic        busy, stall_md;
    logic [31:0] hi, lo;
`ifdef MD_ABORT_EN
    logic        md_abort = 0;
`endif
    int n_checks = 0, n_fail = 0;

    md_sched dut (
        .clk(clk), .reset(reset), .md_start_E(md_start_E), .md_op_E(md_op_E),
        .rs_val_E(rs_val_E), .rt_val_E(rt_val_E), .md_use_D(md_use_D),
`ifdef MD_ABORT_EN
        .md_abort(md_abort),
`endif
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] eh, input logic [31:0] el, input string nm);
        int cyc = 0;
        md_start_E = 1; md_op_E = op; rs_val_E = a; rt_val_E = b;
        tick();
        md_start_E = 0; md_op_E = 3'd6;
        while (busy && cyc < 20) begin
            cyc++;
            tick();
        end
        n_checks++;
        if (cyc !== n) begin n_fail++; $display("FAIL %s busy_cycles got %0d exp %0d", nm, cyc, n); end
        n_checks++;
        if (hi !== eh) begin n_fail++; $display("FAIL %s hi got %h exp %h", nm, hi, eh); end
        n_checks++;
        if (lo !== el) begin n_fail++; $display("FAIL %s lo got %h exp %h", nm, lo, el); end
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset hilo got %h/%h exp 0/0", hi, lo); end
        n_checks++;
        if (stall_md !== 1'b0) begin n_fail++; $display("FAIL reset stall got %b exp 0", stall_md); end
        reset = 0;
        tick();
    endtask

    task automatic test_arith();
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult");
        run_op(3'd1, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE, "multu");
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        run_op(3'd2, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, "div_negdiv");
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, "div_ovf");
        run_op(3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, "divu");
    endtask

    task automatic test_divu_zero();
        md_start_E = 1; md_op_E = 3'd4; rs_val_E = 32'h11;
        tick();
        md_op_E = 3'd5; rs_val_E = 32'h22;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h11) begin n_fail++; $display("FAIL mthi busy/hi got %b/%h exp 0/11", busy, hi); end
        tick();
        md_start_E = 0;
        n_checks++;
        if (lo !== 32'h22 || hi !== 32'h11) begin n_fail++; $display("FAIL mtlo hi/lo got %h/%h exp 11/22", hi, lo); end
        run_op(3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22, "divu_zero");
    endtask

    task automatic test_noop();
        md_start_E = 1; md_op_E = 3'd6; rs_val_E = 32'h99; md_use_D = 1;
        #1;
        n_checks++;
        if (stall_md !== 1'b0) begin n_fail++; $display("FAIL noop stall got %b exp 0", stall_md); end
        tick();
        md_op_E = 3'd7;
        tick();
        md_start_E = 0; md_use_D = 0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
            n_fail++; $display("FAIL noop busy/hi/lo got %b/%h/%h exp 0/11/22", busy, hi, lo);
        end
    endtask

    task automatic test_ignore_busy_start();
        int cyc = 1;
        md_start_E = 1; md_op_E = 3'd3; rs_val_E = 32'd100; rt_val_E = 32'd7;
        tick();
        md_op_E = 3'd1; rs_val_E = 32'hFFFFFFFF; rt_val_E = 32'hFFFFFFFF;
        tick();
        md_start_E = 0;
        while (busy && cyc < 20) begin
            cyc++;
            tick();
        end
        n_checks++;
        if (cyc !== 10) begin n_fail++; $display("FAIL busy_start busy_cycles got %0d exp 10", cyc); end
        n_checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin n_fail++; $display("FAIL busy_start hi/lo got %h/%h exp 2/e", hi, lo); end
    endtask

    task automatic test_stall();
        md_use_D = 1; md_start_E = 1; md_op_E = 3'd0; rs_val_E = 32'd3; rt_val_E = 32'd4;
        #1;
        n_checks++;
        if (stall_md !== 1'b1) begin n_fail++; $display("FAIL stall start got %b exp 1", stall_md); end
        tick();
        md_start_E = 0;
        for (int i = 1; i <= 5; i++) begin
            n_checks++;
            if (stall_md !== 1'b1 || busy !== 1'b1 || lo !== 32'd14) begin
                n_fail++; $display("FAIL stall cycle %0d stall/busy/lo got %b/%b/%h exp 1/1/e", i, stall_md, busy, lo);
            end
            tick();
        end
        n_checks++;
        if (stall_md !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stall drop stall/busy got %b/%b exp 0/0", stall_md, busy); end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd12) begin n_fail++; $display("FAIL stall mflo hi/lo got %h/%h exp 0/c", hi, lo); end
        md_use_D = 0;
    endtask

    task automatic test_reset_mid();
        md_start_E = 1; md_op_E = 3'd2; rs_val_E = 32'd50; rt_val_E = 32'd3;
        tick();
        md_start_E = 0;
        tick(); tick();
        reset = 1;
        tick();
        reset = 0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid busy/hi/lo got %b/%h/%h exp 0/0/0", busy, hi, lo);
        end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_mid late hi/lo got %h/%h exp 0/0", hi, lo); end
    endtask

`ifdef MD_ABORT_EN
    task automatic test_abort();
        md_start_E = 1; md_op_E = 3'd4; rs_val_E = 32'hAA;
        tick();
        md_op_E = 3'd5; rs_val_E = 32'hBB;
        tick();
        md_op_E = 3'd0; rs_val_E = 32'd3; rt_val_E = 32'd4;
        tick();
        md_start_E = 0;
        tick(); tick();
        md_abort = 1;
        tick();
        md_abort = 0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'hAA || lo !== 32'hBB) begin
            n_fail++; $display("FAIL abort busy/hi/lo got %b/%h/%h exp 0/aa/bb", busy, hi, lo);
        end
        md_start_E = 1; md_op_E = 3'd4; rs_val_E = 32'h55; md_abort = 1;
        tick();
        md_start_E = 0; md_abort = 0;
        n_checks++;
        if (busy !== 1'b0 || hi !== 32'hAA) begin n_fail++; $display("FAIL abort_idle busy/hi got %b/%h exp 0/aa", busy, hi); end
        md_start_E = 1; md_op_E = 3'd0; rs_val_E = 32'd3; rt_val_E = 32'd4;
        tick();
        md_start_E = 0;
        for (int i = 0; i < 4; i++) tick();
        md_abort = 1;
        tick();
        md_abort = 0;
        n_checks++;
        if (busy !== 1'b0 || lo !== 32'hBB) begin n_fail++; $display("FAIL abort_last busy/lo got %b/%h exp 0/bb", busy, lo); end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_divu_zero();
        test_noop();
        test_ignore_busy_start();
        test_stall();
        test_reset_mid();
`ifdef MD_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multiply/divide scheduler for the 5-stage MIPS pipeline.
- Accepts MDU ops issued from the E stage and sequences a fixed-latency busy window (MULT 5 cycles, DIV 10 cycles).
- Owns the HI/LO architectural registers.
- Generates the stall that freezes the FD/DE pipeline registers and bubbles the DE→EM path while a dependent MDU instruction waits in D.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (1..15).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  sync active-high reset.
- md_start_E  in  1  MDU instruction valid in E this cycle.
- md_op_E  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op.
- rs_val_E  in  32  forwarded rs operand.
- rt_val_E  in  32  forwarded rt operand.
- md_use_D  in  1  instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
- busy  out  1  an op is in flight.
- stall_md  out  1  stall request to hazard unit: hold FD/DE, flush into EM.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Reset values: state=IDLE, counter=0, busy=0, hi=0, lo=0, pending results=0. stall_md follows combinationally from inputs and state, so it is 0 after reset unless md_start_E&md_use_D are high.
- States:
  - IDLE: on md_start_E with op 0..3, load counter with MULT_CYCLES or DIV_CYCLES, latch the 64-bit result into pending_hi/pending_lo, go to BUSY.
  - BUSY: counter decrements each cycle. At the cycle counter==1: hi<=pending_hi, lo<=pending_lo, go to IDLE.
- busy: registered; high exactly N cycles starting the cycle after start.
- hi/lo: first show the new value in the cycle busy drops.
- MTHI/MTLO: in IDLE, write hi (or lo) <= rs_val_E on the next edge; no busy window.
- Arithmetic:
  - MULT: signed 32x32→64, hi=upper, lo=lower. MULTU: unsigned.
  - DIV/DIVU: lo=quotient, hi=remainder; signed division truncates toward zero, remainder takes the sign of the dividend.
  - Divisor 0: full DIV_CYCLES busy window, hi/lo keep old values.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall_md = md_use_D & (busy | (md_start_E & md_op_E<=3)). Covers the start cycle, so mfhi/mflo in D never reads stale HI/LO.
- md_start_E during BUSY is a protocol violation (the stall prevents it): the op is ignored, and counter, pending and hi/lo are unaffected.
- md_op_E 6/7: ignored.
- Reset mid-operation: abort immediately to reset values; the pending result is discarded.

Optional Feature:
- Macro: MD_ABORT_EN.
- With it: adds input md_abort (1 bit).
  - In BUSY: md_abort forces IDLE, counter=0, busy=0 on the next edge; hi/lo keep pre-op values; pending results are discarded.
  - A start coincident with abort in IDLE is also suppressed.
  - md_abort has priority over the counter==1 commit.
- Without it: no md_abort port; ops always complete.

Test Plan:
- MULT, rs=0xFFFFFFFE (-2), rt=3 -> busy high cycles 1..5 after start; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU, rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV, rs=-7 (0xFFFFFFF9), rt=2 -> 10 busy cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU with rt=0 and hi/lo preloaded by MTHI 0x11 / MTLO 0x22 -> 10 busy cycles; then hi=0x11, lo=0x22 unchanged.
- MULT start with md_use_D=1 held -> stall_md high in the start cycle plus all 5 busy cycles; low the cycle busy drops; mflo reads the new lo.
- Reset asserted at busy cycle 3 of DIV -> next cycle busy=0, hi=lo=0. With MD_ABORT_EN, md_abort at busy cycle 3 -> busy=0, hi/lo hold pre-op values.
